// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register for the 32-bit PA-RISC pipeline.
//               Bubble insertion for stall/flush, nullification carry-over
//               and a saturating inserted-bubble counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module id_ex_stage_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_nullify,
  input  logic        id_valid,
  input  logic [31:0] id_RA,
  input  logic [31:0] id_RB,
  input  logic [20:0] id_I,
  input  logic [2:0]  id_S,
  input  logic [3:0]  id_alu_op,
  input  logic [4:0]  id_rd,
  input  logic        id_rf_le,
  input  logic        id_mem_rd,
  input  logic        id_mem_wr,
  output logic        ex_valid,
  output logic [31:0] ex_RA,
  output logic [31:0] ex_RB,
  output logic [20:0] ex_I,
  output logic [2:0]  ex_S,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_rd,
  output logic        ex_rf_le,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_nullified,
  output logic        nullify_pending,
  output logic [15:0] bubble_count
);

  localparam logic [15:0] C_BC_MAX = 16'hFFFF;

  logic        r_valid;
  logic [31:0] r_ra;
  logic [31:0] r_rb;
  logic [20:0] r_i;
  logic [2:0]  r_s;
  logic [3:0]  r_alu_op;
  logic [4:0]  r_rd;
  logic        r_rf_le;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_nullified;
  logic        r_pending;
  logic [15:0] r_bubble_count;

  logic        w_null_cond;
  logic        w_capture;
  logic        w_nullified_d;
  logic        w_pending_d;
  logic        w_count_bubble;

  // Priority: flush > stall > nullify (with/without a real instruction) > capture.
  always_comb begin
    w_null_cond    = ex_nullify | r_pending;
    w_capture      = 1'b0;
    w_nullified_d  = 1'b0;
    w_pending_d    = r_pending;
    w_count_bubble = 1'b0;
    if (flush) begin
      w_pending_d    = 1'b0;
      w_count_bubble = 1'b1;
    end else if (stall) begin
      w_pending_d    = r_pending | ex_nullify;
      w_count_bubble = 1'b1;
    end else if (w_null_cond) begin
      // An empty ID slot cannot absorb the nullify, so it carries over.
      w_nullified_d  = id_valid;
      w_pending_d    = ~id_valid;
      w_count_bubble = id_valid;
    end else begin
      w_capture      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_ra           <= '0;
      r_rb           <= '0;
      r_i            <= '0;
      r_s            <= '0;
      r_alu_op       <= '0;
      r_rd           <= '0;
      r_rf_le        <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_nullified    <= 1'b0;
      r_pending      <= 1'b0;
      r_bubble_count <= '0;
    end else begin
      r_valid     <= w_capture & id_valid;
      r_ra        <= w_capture ? id_RA     : '0;
      r_rb        <= w_capture ? id_RB     : '0;
      r_i         <= w_capture ? id_I      : '0;
      r_s         <= w_capture ? id_S      : '0;
      r_alu_op    <= w_capture ? id_alu_op : '0;
      r_rd        <= w_capture ? id_rd     : '0;
      r_rf_le     <= w_capture & id_rf_le;
      r_mem_rd    <= w_capture & id_mem_rd;
      r_mem_wr    <= w_capture & id_mem_wr;
      r_nullified <= w_nullified_d;
      r_pending   <= w_pending_d;
      if (w_count_bubble && (r_bubble_count != C_BC_MAX)) begin
        r_bubble_count <= r_bubble_count + 16'd1;
      end
    end
  end

  assign ex_valid        = r_valid;
  assign ex_RA           = r_ra;
  assign ex_RB           = r_rb;
  assign ex_I            = r_i;
  assign ex_S            = r_s;
  assign ex_alu_op       = r_alu_op;
  assign ex_rd           = r_rd;
  assign ex_rf_le        = r_rf_le;
  assign ex_mem_rd       = r_mem_rd;
  assign ex_mem_wr       = r_mem_wr;
  assign ex_nullified    = r_nullified;
  assign nullify_pending = r_pending;
  assign bubble_count    = r_bubble_count;

endmodule

`default_nettype wire

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the 32-bit PA-RISC pipeline. It captures decoded operands and control from the ID stage on each clock and presents them to the EX stage, where `ex_RB`, `ex_I` and `ex_S` drive the second-operand handler directly. It inserts bubbles for hazard stalls and branch flushes, and applies PA-RISC nullification to the next real instruction, including a nullify raised while ID is stalled. A saturating counter records inserted bubbles for performance debug.

## Interface
- No parameters.

Ports:
- `clk` — in, 1: pipeline clock; all state updates on the rising edge.
- `reset` — in, 1: synchronous, active-high.
- `stall` — in, 1: hazard unit load-use stall; ID is held upstream, and this block loads a bubble.
- `flush` — in, 1: branch/exception flush; loads a bubble and cancels any pending nullify.
- `ex_nullify` — in, 1: single-cycle pulse from EX; the instruction in EX met its nullify condition, so the next real instruction must be nullified.
- `id_valid` — in, 1: ID holds a real instruction.
- `id_RA`, `id_RB` — in, 32 each: register operands.
- `id_I` — in, 21: raw immediate field.
- `id_S` — in, 3: operand-handler select.
- `id_alu_op` — in, 4: ALU operation.
- `id_rd` — in, 5: destination register.
- `id_rf_le`, `id_mem_rd`, `id_mem_wr` — in, 1 each: register-write, load and store enables.
- `ex_valid`, `ex_RA`, `ex_RB`, `ex_I`, `ex_S`, `ex_alu_op`, `ex_rd`, `ex_rf_le`, `ex_mem_rd`, `ex_mem_wr` — out, same widths as the corresponding `id_*` inputs: registered copies.
- `ex_nullified` — out, 1: the current EX slot is a bubble created by nullification.
- `nullify_pending` — out, 1: a nullify is recorded and waits for the next real instruction.
- `bubble_count` — out, 16: count of inserted bubbles, saturating.

## Operation
- **Bubble:** every `ex_*` field is loaded with 0, so `ex_valid=0`, all enables are 0, and data, select, op and rd are all 0.
- **Per-edge priority**, first match wins:
  1. `reset`: all outputs 0, `nullify_pending=0`, `bubble_count=0`.
  2. `flush`: load a bubble, set `ex_nullified=0` and `nullify_pending←0`. `ex_nullify` in the same cycle is ignored.
  3. `stall`: load a bubble, set `ex_nullified=0`. If `ex_nullify=1`, set `nullify_pending←1`; otherwise `nullify_pending` holds.
  4. Nullify condition (`ex_nullify | nullify_pending`) with `id_valid=1`: load a bubble, set `ex_nullified=1`, `nullify_pending←0`.
  5. Nullify condition with `id_valid=0`: load a bubble, set `ex_nullified=0`, `nullify_pending←1`. The nullify carries over to the next real instruction.
  6. Otherwise: capture all `id_*` fields into the `ex_*` registers, set `ex_nullified=0`, and leave `nullify_pending` unchanged (it is 0 here).
- **Bubble counter:** `bubble_count` increments by 1 on each edge where case 2, 3 or 4 applies. It holds at 0xFFFF once saturated.
  - Cases 5 and 6 do not count, even when `id_valid=0`.
- A single nullify always consumes exactly one real instruction. Multiple `ex_nullify` pulses while a nullify is already pending do not stack: the flag stays 1.

## Timing
- Latency is one cycle from `id_*` to `ex_*`; there is no combinational path from input to output.
- All outputs, `nullify_pending` and `bubble_count` are registered and update on the rising `clk` edge.
- Reset is synchronous:
  - An edge with `reset=1` forces all-zero state regardless of other inputs.
  - Asserting reset mid-stall, or while a nullify is pending, discards the pending nullify.
- `stall` and `flush` are sampled every edge with no handshake. A multi-cycle stall produces one bubble per stalled cycle, and each one is counted.
- If `ex_nullify` arrives on the same edge as the first non-stalled capture, the nullify is applied to that instruction (case 4).
- After reset, the first edge with `reset=0` behaves like any other edge.

## Test plan
1. **Reset.** Drive all inputs to nonzero values and hold `reset=1` for 2 cycles → every output is 0, including `bubble_count=0` and `nullify_pending=0`.
2. **Capture.**
   - Stimulus: `id_valid=1`, `id_RB=0x8431FFEB`, `id_I=21'h104761`, `id_S=3'b011`, `id_rd=5`, `id_rf_le=1`.
   - Required response one cycle later: `ex_valid=1`, `ex_RB=0x8431FFEB`, `ex_I=21'h104761`, `ex_S=3'b011`, `ex_rd=5`, `ex_rf_le=1`, `bubble_count=0`.
3. **Stall then release.**
   - Stimulus: `stall=1` for 3 cycles with `id_valid=1`.
   - During the stall: `ex_valid=0` and all enables are 0 for 3 cycles; `bubble_count` reaches 3.
   - On release: the held instruction is captured on the next edge.
4. **Nullify during stall.**
   - Stimulus: `stall=1` with a one-cycle `ex_nullify` pulse → `nullify_pending=1`.
   - Release `stall` → the held instruction loads as a bubble with `ex_nullified=1`; then `nullify_pending=0` and `bubble_count=2`.
   - The following instruction is captured normally.
5. **Nullify over an empty slot, then flush.**
   - `ex_nullify=1` with `id_valid=0` → `nullify_pending=1`, `bubble_count` unchanged.
   - Next cycle, `flush=1` with `id_valid=1` → bubble loaded, `nullify_pending=0`, `ex_nullified=0`, `bubble_count+1`.
6. **Saturation.** Hold `stall=1` for 65,540 cycles → `bubble_count` holds at 0xFFFF and does not wrap.
